uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

UART transmit controller that sequences the free-running TX baud counter and serialises bytes onto the `tx` line. Bytes are accepted over a valid/ready handshake into a small FIFO. Each byte is sent as one start bit, DATA_BITS data bits (LSB first) and one stop bit. The block drives the baud counter's active-low reset so that every frame starts on a clean bit boundary, and it sits between the host-side byte source and the serial pin.

## Interface
- BAUD_MAX, 1301: terminal value of the external baud counter; bit period = BAUD_MAX+1 clk cycles.
- DATA_BITS, 8: data bits per frame, range 5..8.
- FIFO_DEPTH, 4: byte FIFO entries, power of 2, ≥2.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- tx_data  in  DATA_BITS  byte to send.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  FIFO can accept; push = tx_valid & tx_ready.
- baud_count  in  11  current value of external baud counter.
- baud_rst_n  out  1  synchronous active-low reset to the baud counter; registered.
- tx  out  1  serial output, idle high; registered.
- busy  out  1  state≠IDLE or FIFO non-empty.
- fifo_level  out  log2(FIFO_DEPTH)+1  entries currently held.

## Operation
- States: IDLE, START, DATA, STOP. tx = 1 in IDLE/STOP, 0 in START, shift_reg[0] in DATA.
- bit_end = (baud_count == BAUD_MAX). Full 11-bit compare; no other count value advances the FSM.
- IDLE: baud_rst_n = 0, which holds the counter at 0. If fifo_level ≠ 0: pop head into shift_reg, go to START, baud_rst_n ← 1.
- START: on bit_end → DATA, bit_idx ← 0.
- DATA: on bit_end: shift_reg >> 1, bit_idx+1. After bit DATA_BITS-1 → STOP.
- STOP: on bit_end:
  - FIFO non-empty: pop, go to START. baud_rst_n stays 1 and the counter wraps naturally, so there is no idle gap.
  - FIFO empty: go to IDLE, baud_rst_n ← 0.
- FIFO:
  - tx_ready = reset & (fifo_level < FIFO_DEPTH).
  - Push and pop may occur on the same edge; the level is then unchanged.
  - No bypass: a byte pushed into an empty FIFO is popped on the next edge.
  - When full, tx_ready = 0 and tx_valid is ignored.
- Reset (reset = 0 at an edge, including mid-frame):
  - State ← IDLE, FIFO flushed (level 0), tx ← 1, baud_rst_n ← 0.
  - The in-flight frame is aborted.
  - tx_ready = 0 while reset is low.
  - busy = 0 after reset.

## Timing
- Byte accepted at edge E with FSM idle and FIFO empty:
  - Edge E+1: START, tx = 0, baud_rst_n = 1.
  - The counter reads 0 during cycle E+1 and reaches BAUD_MAX in cycle E+1+BAUD_MAX.
- Every bit, including the start and stop bits, lasts exactly BAUD_MAX+1 cycles.
- Frame length: (DATA_BITS+2)×(BAUD_MAX+1) cycles; 13020 at the default parameters.
- Back-to-back frames: the next start bit begins on the same edge the stop bit ends.
- Return to IDLE: tx stays 1, and baud_rst_n = 0 from the edge after the last stop-bit cycle.
- tx_ready falls on the edge the level reaches FIFO_DEPTH. It rises on the edge of the pop that frees a slot.

## Test plan
- Reset: hold reset low 3 cycles with tx_valid = 1 → tx = 1, baud_rst_n = 0, fifo_level = 0, busy = 0, tx_ready = 0; no byte accepted.
- Single byte 0xA5 accepted at edge E →
  - tx = 0 on edge E+1.
  - Data bits 1,0,1,0,0,1,0,1, each 1302 cycles.
  - Stop bit 1.
  - IDLE with baud_rst_n = 0 at edge E+1+13020; busy falls on the same edge.
- Back-to-back 0x00 then 0xFF → second start bit begins exactly 13020 cycles after the first, with no high gap; the data bits of the second frame are all 1.
- FIFO full, with the block idle:
  - Offer 6 bytes continuously: the first 5 are accepted on consecutive edges (the first is popped at edge 2).
  - After the 5th push: fifo_level = 4, tx_ready = 0.
  - The 6th byte is accepted 1 cycle after the first frame's stop bit ends.
  - All 6 bytes appear on tx in order.
- Reset mid-frame: assert reset during data bit 3 of 0x3C with 2 bytes queued → tx = 1 next edge, fifo_level = 0, and no further frames are sent after reset is released.
- Counter alignment: force baud_count = 1301 while IDLE with the FIFO empty → no state change. After a push, the start bit still lasts 1302 cycles.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit controller.
// Queues host bytes in a small FIFO and serialises each one as a start bit,
// DATA_BITS data bits (LSB first) and a stop bit. It also holds the external
// free-running baud counter in reset while idle, so that every frame starts
// on a clean bit boundary.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-low reset
//   tx_data     byte to send
//   tx_valid    tx_data valid
//   tx_ready    FIFO can accept (push = tx_valid & tx_ready)
//   baud_count  current value of the external baud counter
//   baud_rst_n  synchronous active-low reset to the baud counter (registered)
//   tx          serial output, idle high (registered)
//   busy        frame in progress or FIFO non-empty (registered)
//   fifo_level  number of bytes held in the FIFO
module uart_tx_ctrl #(
    parameter int unsigned BAUD_MAX   = 1301,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic [10:0]                   baud_count,
    output logic                          baud_rst_n,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned CNT_W = 11;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_nxt;
    logic [IDX_W-1:0]     bit_idx;
    logic [IDX_W-1:0]     bit_idx_nxt;
    logic                 tx_nxt;
    logic                 baud_rst_n_nxt;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [LVL_W-1:0]     level;
    logic [LVL_W-1:0]     level_nxt;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic                 bit_end;

    // Only the exact terminal count ends a bit period.
    assign bit_end    = (baud_count == CNT_W'(BAUD_MAX));
    assign fifo_empty = (level == '0);
    assign tx_ready   = reset & (level < LVL_W'(FIFO_DEPTH));
    assign push       = tx_valid & tx_ready;
    assign fifo_level = level;

    // Next-state, pop request and registered-output next values.
    always_comb begin
        state_nxt      = state;
        shift_nxt      = shift_reg;
        bit_idx_nxt    = bit_idx;
        baud_rst_n_nxt = baud_rst_n;
        pop            = 1'b0;

        case (state)
            IDLE: begin
                baud_rst_n_nxt = 1'b0;
                if (!fifo_empty) begin
                    pop            = 1'b1;
                    shift_nxt      = mem[rd_ptr];
                    state_nxt      = START;
                    baud_rst_n_nxt = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt   = DATA;
                    bit_idx_nxt = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_nxt = shift_reg >> 1;
                    if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        // Counter wraps on its own here, so no idle gap.
                        pop       = 1'b1;
                        shift_nxt = mem[rd_ptr];
                        state_nxt = START;
                    end else begin
                        state_nxt      = IDLE;
                        baud_rst_n_nxt = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt      = IDLE;
                baud_rst_n_nxt = 1'b0;
            end
        endcase

        // Line level follows the state being entered.
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
    end

    // FIFO occupancy after this edge's push/pop.
    always_comb begin
        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + LVL_W'(1);
        end else if (!push && pop) begin
            level_nxt = level - LVL_W'(1);
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_idx    <= '0;
            tx         <= 1'b1;
            baud_rst_n <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            shift_reg  <= shift_nxt;
            bit_idx    <= bit_idx_nxt;
            tx         <= tx_nxt;
            baud_rst_n <= baud_rst_n_nxt;
            busy       <= (state_nxt != IDLE) || (level_nxt != '0);
        end
    end

    // FIFO pointers and level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level_nxt;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl. Instance A uses the default parameters for the
// exact-timing directed sequences; instance B uses a short bit period and is
// checked every cycle against a frame-level reference model.
module tb_uart_tx_ctrl;

    localparam int unsigned BM_A = 1301;
    localparam int BP_A = 1302;
    localparam int unsigned BM_B = 9;
    localparam int BP_B = 10;
    localparam int FR_B = 10 * BP_B;
    localparam int FD   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A (default parameters) ----------------
    logic        a_reset, a_tx_valid, a_tx_ready, a_baud_rst_n, a_tx, a_busy;
    logic [7:0]  a_tx_data;
    logic [10:0] a_baud_count, a_cnt;
    logic [2:0]  a_fifo_level;
    logic        a_force;

    assign a_baud_count = a_force ? 11'(BM_A) : a_cnt;

    always @(posedge clk) begin
        if (!a_baud_rst_n)              a_cnt <= '0;
        else if (a_cnt == 11'(BM_A))    a_cnt <= '0;
        else                            a_cnt <= a_cnt + 11'd1;
    end

    uart_tx_ctrl u_a (
        .clk        (clk),
        .reset      (a_reset),
        .tx_data    (a_tx_data),
        .tx_valid   (a_tx_valid),
        .tx_ready   (a_tx_ready),
        .baud_count (a_baud_count),
        .baud_rst_n (a_baud_rst_n),
        .tx         (a_tx),
        .busy       (a_busy),
        .fifo_level (a_fifo_level)
    );

    // ---------------- instance B (short bit period) ----------------
    logic        b_reset, b_tx_valid, b_tx_ready, b_baud_rst_n, b_tx, b_busy;
    logic [7:0]  b_tx_data;
    logic [10:0] b_cnt;
    logic [2:0]  b_fifo_level;

    always @(posedge clk) begin
        if (!b_baud_rst_n)              b_cnt <= '0;
        else if (b_cnt == 11'(BM_B))    b_cnt <= '0;
        else                            b_cnt <= b_cnt + 11'd1;
    end

    uart_tx_ctrl #(.BAUD_MAX(BM_B), .DATA_BITS(8), .FIFO_DEPTH(FD)) u_b (
        .clk        (clk),
        .reset      (b_reset),
        .tx_data    (b_tx_data),
        .tx_valid   (b_tx_valid),
        .tx_ready   (b_tx_ready),
        .baud_count (b_cnt),
        .baud_rst_n (b_baud_rst_n),
        .tx         (b_tx),
        .busy       (b_busy),
        .fifo_level (b_fifo_level)
    );

    // ---------------- bookkeeping ----------------
    int n_tot = 0;
    int n_bad = 0;
    bit chk_b = 1'b0;

    // Reference model for B: byte queue plus position inside the current frame.
    logic [7:0] mq[$];
    logic [7:0] m_sent[$];
    logic [7:0] m_cur = 8'h00;
    int         m_t = -1;

    // Independent line decoder for B.
    logic [7:0] rxq[$];
    logic [7:0] rx_sh = 8'h00;
    int         rx_ph = -1;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;
    vec_t tbl[6];
    logic [7:0] fill[6];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit rdy;
        if (!b_reset) begin
            mq.delete();
            m_t = -1;
        end else begin
            rdy = (mq.size() < FD);
            if (m_t < 0) begin
                if (mq.size() != 0) begin
                    m_cur = mq.pop_front();
                    m_t   = 0;
                end
            end else if (m_t == FR_B - 1) begin
                m_sent.push_back(m_cur);
                if (mq.size() != 0) begin
                    m_cur = mq.pop_front();
                    m_t   = 0;
                end else begin
                    m_t = -1;
                end
            end else begin
                m_t++;
            end
            if (b_tx_valid && rdy) mq.push_back(b_tx_data);
        end
    endtask

    function automatic logic model_tx();
        int k;
        if (m_t < 0) return 1'b1;
        k = m_t / BP_B;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_cur[k-1];
        return 1'b1;
    endfunction

    task automatic rx_step();
        int k;
        if (!b_reset) begin
            rx_ph = -1;
        end else if (rx_ph < 0) begin
            if (b_tx === 1'b0) rx_ph = 0;
        end else begin
            rx_ph++;
            if (rx_ph % BP_B == BP_B / 2) begin
                k = rx_ph / BP_B;
                if (k >= 1 && k <= 8) rx_sh[k-1] = b_tx;
                if (k == 9) begin
                    rxq.push_back(rx_sh);
                    rx_ph = -1;
                end
            end
        end
    endtask

    task automatic check_b();
        logic [6:0] got, exp;
        logic       rdy, act;
        act = (m_t >= 0);
        rdy = b_reset && (mq.size() < FD);
        exp = {model_tx(), act, 3'(mq.size()), rdy, act || (mq.size() != 0)};
        got = {b_tx, b_baud_rst_n, b_fifo_level, b_tx_ready, b_busy};
        chk("b_model{tx,brn,lvl,rdy,busy}", 32'(got), 32'(exp));
    endtask

    // One clock: model advances on the rising edge, outputs sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        rx_step();
        if (chk_b) check_b();
    endtask

    // Walks one A frame starting at its first cycle; counts correct cycles per bit.
    task automatic check_frame_a(input logic [7:0] d);
        logic eb;
        int   good;
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      eb = 1'b0;
            else if (k == 9) eb = 1'b1;
            else             eb = d[k-1];
            good = 0;
            for (int c = 0; c < BP_A; c++) begin
                if (a_tx === eb && a_baud_rst_n === 1'b1 && a_busy === 1'b1) good++;
                tick();
            end
            chk($sformatf("a_frame_%02h_bit%0d", d, k), 32'(good), 32'(BP_A));
        end
    endtask

    task automatic check_idle_a(input string nm);
        chk({nm, "_tx"},   32'(a_tx), 32'd1);
        chk({nm, "_brn"},  32'(a_baud_rst_n), 32'd0);
        chk({nm, "_busy"}, 32'(a_busy), 32'd0);
        chk({nm, "_lvl"},  32'(a_fifo_level), 32'd0);
    endtask

    initial begin
        int n, good, n0, lows, mis;
        logic [9:0] got;

        tbl[0] = '{8'hA5, 10'h34A};
        tbl[1] = '{8'h00, 10'h200};
        tbl[2] = '{8'hFF, 10'h3FE};
        tbl[3] = '{8'h3C, 10'h278};
        tbl[4] = '{8'h81, 10'h302};
        tbl[5] = '{8'h5A, 10'h2B4};
        fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33;
        fill[3] = 8'h44; fill[4] = 8'h55; fill[5] = 8'h66;

        a_reset = 1'b0; a_tx_valid = 1'b1; a_tx_data = 8'h77; a_force = 1'b0;
        b_reset = 1'b0; b_tx_valid = 1'b0; b_tx_data = 8'h00;

        // Reset held 3 cycles with tx_valid high.
        repeat (3) tick();
        check_idle_a("a_reset");
        chk("a_reset_ready", 32'(a_tx_ready), 32'd0);
        chk_b = 1'b1;
        a_tx_valid = 1'b0;
        a_reset = 1'b1;
        b_reset = 1'b1;
        tick();
        chk("a_post_reset_lvl", 32'(a_fifo_level), 32'd0);
        chk("a_post_reset_ready", 32'(a_tx_ready), 32'd1);

        // Single byte 0xA5 at default timing.
        a_tx_data = 8'hA5; a_tx_valid = 1'b1;
        tick();
        a_tx_valid = 1'b0;
        chk("a_single_lvl", 32'(a_fifo_level), 32'd1);
        chk("a_single_tx_idle", 32'(a_tx), 32'd1);
        tick();
        check_frame_a(8'hA5);
        check_idle_a("a_single_end");

        // Back-to-back 0x00 then 0xFF.
        a_tx_data = 8'h00; a_tx_valid = 1'b1;
        tick();
        a_tx_data = 8'hFF;
        tick();
        a_tx_valid = 1'b0;
        chk("a_b2b_lvl", 32'(a_fifo_level), 32'd1);
        check_frame_a(8'h00);
        check_frame_a(8'hFF);
        check_idle_a("a_b2b_end");

        // Terminal count seen while idle must not move the FSM.
        a_force = 1'b1;
        good = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (a_tx === 1'b1 && a_baud_rst_n === 1'b0 && a_busy === 1'b0) good++;
        end
        chk("a_force_idle", 32'(good), 32'd8);
        a_force = 1'b0;
        a_tx_data = 8'h81; a_tx_valid = 1'b1;
        tick();
        a_tx_valid = 1'b0;
        tick();
        n = 0;
        while (a_tx === 1'b0 && n < BP_A + 10) begin
            n++;
            tick();
        end
        chk("a_align_start_len", 32'(n), 32'(BP_A));
        chk("a_align_bit0", 32'(a_tx), 32'd1);
        a_reset = 1'b0;
        tick();
        a_reset = 1'b1;
        check_idle_a("a_align_reset");

        // Table of single frames on B, sampled at mid-bit.
        for (int i = 0; i < 6; i++) begin
            b_tx_data = tbl[i].data; b_tx_valid = 1'b1;
            tick();
            b_tx_valid = 1'b0;
            tick();
            got = '0;
            for (int c = 0; c < FR_B; c++) begin
                if (c % BP_B == BP_B / 2) got[c / BP_B] = b_tx;
                tick();
            end
            chk($sformatf("b_tbl_frame_%02h", tbl[i].data), 32'(got), 32'(tbl[i].frame));
            chk($sformatf("b_tbl_busy_%02h", tbl[i].data), 32'(b_busy), 32'd0);
        end

        // Offer 6 bytes continuously to an idle B.
        n0 = rxq.size();
        b_tx_valid = 1'b1; b_tx_data = fill[0];
        for (int i = 1; i < 5; i++) begin
            chk("b_fill_ready", 32'(b_tx_ready), 32'd1);
            tick();
            b_tx_data = fill[i];
        end
        chk("b_fill_ready", 32'(b_tx_ready), 32'd1);
        tick();
        b_tx_data = fill[5];
        chk("b_full_lvl", 32'(b_fifo_level), 32'd4);
        chk("b_full_ready", 32'(b_tx_ready), 32'd0);
        n = 0;
        while (b_tx_ready !== 1'b1 && n < 2 * FR_B) begin
            tick();
            n++;
        end
        chk("b_full_wait", 32'(n), 32'(FR_B - 3));
        tick();
        b_tx_valid = 1'b0;
        chk("b_refill_lvl", 32'(b_fifo_level), 32'd4);
        n = 0;
        while ((rxq.size() < n0 + 6 || b_busy !== 1'b0) && n < 7 * FR_B) begin
            tick();
            n++;
        end
        chk("b_fill_rx_count", 32'(rxq.size() - n0), 32'd6);
        mis = 0;
        for (int i = 0; i < 6; i++) begin
            if (n0 + i < rxq.size() && rxq[n0 + i] !== fill[i]) mis++;
        end
        chk("b_fill_order", 32'(mis), 32'd0);

        // Reset during data bit 3 of 0x3C with two bytes queued.
        b_tx_data = 8'h3C; b_tx_valid = 1'b1;
        tick();
        b_tx_data = 8'hC1;
        tick();
        b_tx_data = 8'hC2;
        tick();
        b_tx_valid = 1'b0;
        chk("b_abort_lvl", 32'(b_fifo_level), 32'd2);
        repeat (44) tick();
        chk("b_abort_bit3", 32'(b_tx), 32'd1);
        b_reset = 1'b0;
        tick();
        chk("b_abort_tx", 32'(b_tx), 32'd1);
        chk("b_abort_lvl0", 32'(b_fifo_level), 32'd0);
        chk("b_abort_brn", 32'(b_baud_rst_n), 32'd0);
        chk("b_abort_busy", 32'(b_busy), 32'd0);
        chk("b_abort_ready", 32'(b_tx_ready), 32'd0);
        b_reset = 1'b1;
        n0 = rxq.size();
        lows = 0;
        for (int i = 0; i < 3 * FR_B; i++) begin
            tick();
            if (b_tx !== 1'b1) lows++;
        end
        chk("b_abort_quiet", 32'(lows), 32'd0);
        chk("b_abort_no_rx", 32'(rxq.size() - n0), 32'd0);

        // Random traffic with varying offered load.
        for (int i = 0; i < 4000; i++) begin
            int dens;
            case (i / 1000)
                0:       dens = 5;
                1:       dens = 30;
                2:       dens = 90;
                default: dens = 2;
            endcase
            b_tx_valid = ($urandom_range(0, 99) < dens);
            b_tx_data  = 8'($urandom);
            tick();
        end
        b_tx_valid = 1'b0;
        n = 0;
        while ((m_t >= 0 || mq.size() != 0 || b_busy !== 1'b0) && n < 6 * FR_B) begin
            tick();
            n++;
        end
        chk("b_rand_drain", 32'(b_busy), 32'd0);
        chk("b_rx_count", 32'(rxq.size()), 32'(m_sent.size()));
        mis = 0;
        for (int i = 0; i < rxq.size() && i < m_sent.size(); i++) begin
            if (rxq[i] !== m_sent[i]) mis++;
        end
        chk("b_rx_order", 32'(mis), 32'd0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
